slt_serial_ctrl: RTL and testbench
==================================

Name: slt_serial_ctrl

Overview:
- Multi-cycle sequencer for set-less-than (SLT/SLTU) in the MIPS ALU.
- Captures two operands and walks them LSB-to-MSB through the 1-bit SLT cell, carrying the less-than chain in a register. Processes BPC bits per cycle.
- Drives a zero-extended 0/1 result to the register-file writeback mux, using a start/busy/done handshake.
- Trades latency for a single-cell datapath in the area-reduced core variant.

Parameters:
- WIDTH, 32, operand and result width in bits.
- BPC, 1, bits processed per cycle. Must divide WIDTH; elaboration error otherwise.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous active-high reset.
- start  input  1  request. Sampled only in IDLE.
- signed_op  input  1  1 = SLT (two's complement), 0 = SLTU. Captured with start.
- rs_in  input  WIDTH  operand A. Captured with start.
- rt_in  input  WIDTH  operand B. Captured with start.
- busy  output  1  high whenever state is not IDLE.
- done  output  1  one-cycle pulse when rd_out becomes valid.
- rd_out  output  WIDTH  result {WIDTH-1 zeros, lt}. Held until the next completion.

Behaviour:
- Reset (async, any state): state=IDLE; busy=0; done=0; rd_out=0; ltc=0; bit counter=0; operand registers=0.
- States:
  - IDLE: on start=1, capture rs_in, rt_in and signed_op; ltc<=0; cnt<=0; go to RUN. Otherwise stay.
  - RUN: each cycle applies BPC chained cell evaluations to bits [cnt*BPC +: BPC], LSB first.
    - Cell function: out = (b & ~a) | (~(a^b) & ltc_in).
    - For a normal bit: a = rs bit, b = rt bit.
    - ltc <= output of the last cell in the chunk; cnt <= cnt+1.
    - When cnt == WIDTH/BPC-1, the final chunk is evaluated this cycle: rd_out <= {0.., final out}; go to DONE.
  - DONE: done=1 for exactly this cycle; next cycle go to IDLE.
- Signed handling: in the chunk containing bit WIDTH-1, when signed_op=1, the MSB cell is fed with a and b swapped (a = rt MSB, b = rs MSB). This gives the two's-complement ordering.
- Latency: start sampled at edge E0; done high during the cycle after edge E0+N, where N = WIDTH/BPC. WIDTH=32, BPC=1 gives 33 cycles from acceptance to done; BPC=4 gives 9.
- start while busy (RUN or DONE) is ignored, not queued.
- Back-to-back: earliest next acceptance is the IDLE cycle after DONE.
- Operand inputs may change freely after acceptance; the captured copies are used.
- Equal operands: result 0 (chain stays 0).
- Reset asserted mid-RUN: operation is discarded, no done, rd_out=0.
- rd_out changes only at the DONE transition and on reset.

Optional Feature:
- Macro: SLT_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 in RUN: next state IDLE, no done, rd_out unchanged, ltc/cnt cleared.
  - abort in IDLE or DONE: ignored.
  - abort and start both high in IDLE: start wins.
- Undefined: no abort port; RUN always completes.

Decomposition:
- Shared package (alu_pkg): state encoding typedef (IDLE=2'b00, RUN=2'b01, DONE=2'b10); constant ALU_WIDTH=32; op-select constant for SLT/SLTU used by the ALU decoder.
- One sub-module, slt_bit_cell: combinational 1-bit cell with ports a, b, ltc_in, lt_out. Instantiated BPC times in a generate chain.
- The controller owns the FSM, counter, operand registers and the MSB swap mux.

Test Plan:
- SLTU, rs=5, rt=9 (WIDTH=32, BPC=1) -> done pulses at cycle 33 after acceptance; rd_out=1; busy high cycles 1-33.
- SLT, rs=0xFFFFFFFF (-1), rt=0x00000001 -> rd_out=1. SLTU with the same operands -> rd_out=0.
- Equal operands, rs=rt=0x80000000, signed and unsigned -> rd_out=0 in both cases.
- start pulsed again at cycle 10 of a run with different operands -> ignored; the original result is delivered; a new start in IDLE is then accepted.
- rst asserted at cycle 15 of a run -> busy=0 and rd_out=0 immediately (asynchronous); no done pulse follows.
- SLT_ABORT_EN build, abort at RUN cycle 5 after a previous result of 1 -> returns to IDLE, no done, rd_out stays 1. BPC=4 regression: rs=0x7FFFFFFF, rt=0x80000000 signed -> rd_out=0, done at cycle 9.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the MIPS ALU and its serial set-less-than sequencer.
//   - state_e     : sequencer state encoding (IDLE/RUN/DONE)
//   - ALU_WIDTH   : architectural datapath width
//   - ALU_OP_SLT / ALU_OP_SLTU : op-select codes the ALU decoder steers here
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int ALU_WIDTH = 32;

  // Op-select codes used by the ALU decoder to route SLT/SLTU to the sequencer.
  localparam logic [3:0] ALU_OP_SLT  = 4'b0111;
  localparam logic [3:0] ALU_OP_SLTU = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // True when the decoded op belongs to the set-less-than family.
  function automatic logic is_slt_op(input logic [3:0] op);
    return (op == ALU_OP_SLT) || (op == ALU_OP_SLTU);
  endfunction

endpackage

// File: rtl/slt_bit_cell.sv
// ---------------------------------------------------------------------------
// slt_bit_cell
// Combinational 1-bit less-than cell. Chained LSB to MSB, the final lt_out
// is 1 when operand a < operand b.
// Ports:
//   a, b    : operand bits at this position
//   ltc_in  : less-than verdict of the lower-order bits
//   lt_out  : less-than verdict including this bit
// ---------------------------------------------------------------------------
module slt_bit_cell (
  input  logic a,
  input  logic b,
  input  logic ltc_in,
  output logic lt_out
);

  // A differing bit decides the comparison; equal bits pass the lower verdict.
  assign lt_out = (b & ~a) | (~(a ^ b) & ltc_in);

endmodule

// File: rtl/slt_serial_ctrl.sv
// ---------------------------------------------------------------------------
// slt_serial_ctrl
// Multi-cycle SLT/SLTU sequencer. Captures two operands on start, walks them
// LSB to MSB through BPC chained slt_bit_cell instances per cycle, and
// delivers a zero-extended 0/1 result with a start/busy/done handshake.
// Parameters:
//   WIDTH : operand/result width
//   BPC   : bits evaluated per cycle (must divide WIDTH)
// Ports:
//   clk, rst         : rising-edge clock, asynchronous active-high reset
//   start            : request, sampled only in IDLE
//   signed_op        : 1 = SLT (two's complement), 0 = SLTU
//   rs_in, rt_in     : operands A and B
//   busy             : high whenever not IDLE
//   done             : one-cycle pulse when rd_out becomes valid
//   rd_out           : {WIDTH-1 zeros, lt}, held until the next completion
// Build option:
//   SLT_ABORT_EN     : adds input abort; abort in RUN drops the operation.
// ---------------------------------------------------------------------------
module slt_serial_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
`ifdef SLT_ABORT_EN
  input  logic             abort,
`endif
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] rs_in,
  input  logic [WIDTH-1:0] rt_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rd_out
);

  localparam int N_CHUNKS = WIDTH / BPC;
  localparam int CNT_W    = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  if ((WIDTH % BPC) != 0) begin : g_bad_bpc
    $error("slt_serial_ctrl: BPC must divide WIDTH");
  end

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   rs_q, rs_d;
  logic [WIDTH-1:0]   rt_q, rt_d;
  logic [WIDTH-1:0]   rd_q, rd_d;
  logic               signed_q, signed_d;
  logic               ltc_q, ltc_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               last_chunk;
  logic [BPC-1:0]     cell_a, cell_b;
  logic [BPC:0]       chain;

  assign last_chunk = (cnt_q == CNT_W'(N_CHUNKS - 1));

  // Operands shift right each cycle, so the current chunk is always the low
  // BPC bits. In the final chunk the top cell sees the original MSBs, which
  // are swapped for signed compares to flip the sign-bit ordering.
  always_comb begin
    cell_a = rs_q[BPC-1:0];
    cell_b = rt_q[BPC-1:0];
    if (last_chunk && signed_q) begin
      cell_a[BPC-1] = rt_q[BPC-1];
      cell_b[BPC-1] = rs_q[BPC-1];
    end
  end

  assign chain[0] = ltc_q;

  for (genvar i = 0; i < BPC; i++) begin : g_cell
    slt_bit_cell u_cell (
      .a      (cell_a[i]),
      .b      (cell_b[i]),
      .ltc_in (chain[i]),
      .lt_out (chain[i+1])
    );
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    state_d  = state_q;
    rs_d     = rs_q;
    rt_d     = rt_q;
    rd_d     = rd_q;
    signed_d = signed_q;
    ltc_d    = ltc_q;
    cnt_d    = cnt_q;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          rs_d     = rs_in;
          rt_d     = rt_in;
          signed_d = signed_op;
          ltc_d    = 1'b0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        ltc_d = chain[BPC];
        cnt_d = cnt_q + CNT_W'(1);
        rs_d  = rs_q >> BPC;
        rt_d  = rt_q >> BPC;
        if (last_chunk) begin
          rd_d    = '0;
          rd_d[0] = chain[BPC];
          state_d = ST_DONE;
        end
`ifdef SLT_ABORT_EN
        if (abort) begin
          rd_d    = rd_q;
          ltc_d   = 1'b0;
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
`endif
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: every register, operands included, is reset so a reset mid-RUN
  // leaves no stale operand or partial verdict behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      rs_q     <= '0;
      rt_q     <= '0;
      rd_q     <= '0;
      signed_q <= 1'b0;
      ltc_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q  <= state_d;
      rs_q     <= rs_d;
      rt_q     <= rt_d;
      rd_q     <= rd_d;
      signed_q <= signed_d;
      ltc_q    <= ltc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign busy   = (state_q != ST_IDLE);
  assign done   = (state_q == ST_DONE);
  assign rd_out = rd_q;

endmodule

// File: tb/tb_slt_serial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_slt_serial_ctrl
// Bench for slt_serial_ctrl: a BPC=1 and a BPC=4 instance, directed cases
// plus randomized operands compared with a plain-arithmetic comparison model.
// ---------------------------------------------------------------------------
module tb_slt_serial_ctrl;

  localparam int WIDTH = 32;
  localparam int LIMIT = 200;

  logic             clk = 1'b0;
  logic             rst = 1'b1;

  logic             start1 = 1'b0, signed1 = 1'b0;
  logic [WIDTH-1:0] rs1 = '0, rt1 = '0;
  logic             busy1, done1;
  logic [WIDTH-1:0] rd1;

  logic             start4 = 1'b0, signed4 = 1'b0;
  logic [WIDTH-1:0] rs4 = '0, rt4 = '0;
  logic             busy4, done4;
  logic [WIDTH-1:0] rd4;

`ifdef SLT_ABORT_EN
  logic abort1 = 1'b0;
  logic abort4 = 1'b0;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  slt_serial_ctrl #(.WIDTH(WIDTH), .BPC(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
`ifdef SLT_ABORT_EN
    .abort     (abort1),
`endif
    .start     (start1),
    .signed_op (signed1),
    .rs_in     (rs1),
    .rt_in     (rt1),
    .busy      (busy1),
    .done      (done1),
    .rd_out    (rd1)
  );

  slt_serial_ctrl #(.WIDTH(WIDTH), .BPC(4)) u_dut4 (
    .clk       (clk),
    .rst       (rst),
`ifdef SLT_ABORT_EN
    .abort     (abort4),
`endif
    .start     (start4),
    .signed_op (signed4),
    .rs_in     (rs4),
    .rt_in     (rt4),
    .busy      (busy4),
    .done      (done4),
    .rd_out    (rd4)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the architectural meaning of SLT/SLTU.
  function automatic logic [WIDTH-1:0] ref_slt(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b,
                                               input logic s);
    logic lt;
    if (s) lt = ($signed(a) < $signed(b));
    else   lt = (a < b);
    return {{(WIDTH-1){1'b0}}, lt};
  endfunction

  task automatic pick_operands(output logic [WIDTH-1:0] a, output logic [WIDTH-1:0] b);
    a = $urandom;
    case ($urandom_range(0, 3))
      0: b = $urandom;
      1: b = a;
      2: b = a ^ {1'b1, {(WIDTH-1){1'b0}}};
      default: begin a = $urandom_range(0, 15); b = $urandom_range(0, 15); end
    endcase
  endtask

  // One operation on the BPC=1 instance. poke > 0 re-asserts start with other
  // operands in that RUN cycle; it must be ignored.
  task automatic op1(input string tag, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] b, input logic s, input int poke);
    int k;
    int nbusy;
    bit got;
    logic [WIDTH-1:0] exp;
    exp = ref_slt(a, b, s);
    @(negedge clk);
    start1 = 1'b1; rs1 = a; rt1 = b; signed1 = s;
    @(negedge clk);
    nbusy = 0;
    got = 1'b0;
    for (k = 1; k <= LIMIT; k++) begin
      if (busy1) nbusy++;
      if (done1) begin got = 1'b1; break; end
      start1  = (k == poke);
      rs1     = $urandom;
      rt1     = $urandom;
      signed1 = $urandom_range(0, 1);
      @(negedge clk);
    end
    start1 = 1'b0;
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, "_latency"}, 64'(k), 64'(WIDTH + 1));
      check({tag, "_busy_cycles"}, 64'(nbusy), 64'(WIDTH + 1));
      check({tag, "_rd"}, 64'(rd1), 64'(exp));
      @(negedge clk);
      check({tag, "_done_pulse"}, {62'd0, busy1, done1}, 64'd0);
      check({tag, "_rd_hold"}, 64'(rd1), 64'(exp));
    end
  endtask

  task automatic op4(input string tag, input logic [WIDTH-1:0] a,
                     input logic [WIDTH-1:0] b, input logic s);
    int k;
    bit got;
    logic [WIDTH-1:0] exp;
    exp = ref_slt(a, b, s);
    @(negedge clk);
    start4 = 1'b1; rs4 = a; rt4 = b; signed4 = s;
    @(negedge clk);
    start4 = 1'b0;
    got = 1'b0;
    for (k = 1; k <= LIMIT; k++) begin
      if (done4) begin got = 1'b1; break; end
      rs4 = $urandom;
      rt4 = $urandom;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    if (got) begin
      check({tag, "_latency"}, 64'(k), 64'(WIDTH / 4 + 1));
      check({tag, "_rd"}, 64'(rd4), 64'(exp));
    end
  endtask

  initial begin
    logic [WIDTH-1:0] a, b;
    logic s;
    int ndone;

    #2;
    check("reset_busy1", 64'(busy1), 64'd0);
    check("reset_done1", 64'(done1), 64'd0);
    check("reset_rd1", 64'(rd1), 64'd0);
    check("reset_busy4", 64'(busy4), 64'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // BPC=4 regression and random operations.
    op4("b4_pos_vs_neg", 32'h7FFF_FFFF, 32'h8000_0000, 1'b1);
    op4("b4_neg_lt_pos", 32'hFFFF_FFFF, 32'h0000_0001, 1'b1);
    for (int i = 0; i < 10; i++) begin
      pick_operands(a, b);
      s = $urandom_range(0, 1);
      op4($sformatf("b4_rand%0d", i), a, b, s);
    end

    // BPC=1 directed cases.
    op1("sltu_5_9", 32'd5, 32'd9, 1'b0, 0);
    op1("slt_m1_1", 32'hFFFF_FFFF, 32'h1, 1'b1, 0);
    op1("sltu_m1_1", 32'hFFFF_FFFF, 32'h1, 1'b0, 0);
    op1("slt_eq_msb", 32'h8000_0000, 32'h8000_0000, 1'b1, 0);
    op1("sltu_eq_msb", 32'h8000_0000, 32'h8000_0000, 1'b0, 0);
    op1("restart_ignored", 32'd3, 32'd2, 1'b0, 10);
    op1("accept_after", 32'd2, 32'd3, 1'b0, 0);

    for (int i = 0; i < 10; i++) begin
      pick_operands(a, b);
      s = $urandom_range(0, 1);
      op1($sformatf("b1_rand%0d", i), a, b, s, 0);
    end

`ifdef SLT_ABORT_EN
    op1("pre_abort", 32'd1, 32'd2, 1'b0, 0);
    @(negedge clk);
    start1 = 1'b1; rs1 = 32'd9; rt1 = 32'd1; signed1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    repeat (4) @(negedge clk);
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0;
    check("abort_idle", 64'(busy1), 64'd0);
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      if (done1) ndone++;
      @(negedge clk);
    end
    check("abort_no_done", 64'(ndone), 64'd0);
    check("abort_rd_kept", 64'(rd1), 64'd1);
    op1("after_abort", 32'hFFFF_FFFE, 32'd0, 1'b1, 0);
`endif

    // Make rd_out 1 so the asynchronous clear is observable.
    op1("pre_reset", 32'd0, 32'd7, 1'b0, 0);
    @(negedge clk);
    start1 = 1'b1; rs1 = 32'd1; rt1 = 32'd8; signed1 = 1'b0;
    @(negedge clk);
    start1 = 1'b0;
    repeat (14) @(negedge clk);
    check("mid_run_busy", 64'(busy1), 64'd1);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", 64'(busy1), 64'd0);
    check("async_rst_rd", 64'(rd1), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done1) ndone++;
    end
    check("rst_no_done", 64'(ndone), 64'd0);
    check("rst_rd_zero", 64'(rd1), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
